// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register map and STATUS bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_RETURN = 2'd3
  } irq_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_EPC     = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int STATUS_GIE  = 0;
  localparam int STATUS_PGIE = 1;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending sources.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // NOTE: every output of a combinational block gets a default first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    id    = '0;
    valid = |req;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller with edge-detected sources and a
// take/return FSM. Define IRQ_CTRL_VECTORED_EN for per-source vectors.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         irq_src,
  input  logic                       reg_we,
  input  logic [1:0]                 reg_addr,
  input  logic [31:0]                reg_wdata,
  output logic [31:0]                reg_rdata,
  input  logic [31:0]                pc_in,
  input  logic                       mret,
  output logic                       redirect,
  output logic [31:0]                redirect_pc,
  output logic                       irq_active,
  output logic [$clog2(NUM_SRC)-1:0] irq_id
);

  localparam int ID_W = $clog2(NUM_SRC);

  irq_state_e           state;
  logic [NUM_SRC-1:0]   prev_src;
  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   enable;
  logic [31:0]          epc;
  logic                 gie;
  logic                 pgie;

  logic [NUM_SRC-1:0]   pend_set;
  logic [NUM_SRC-1:0]   pend_clr;
  logic [NUM_SRC-1:0]   take_clr;
  logic [ID_W-1:0]      enc_id;
  logic                 enc_valid;
  logic                 take_req;
  logic [31:0]          take_pc;
  logic                 unused_wdata;

  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_prio_enc (
    .req   (pending & enable),
    .id    (enc_id),
    .valid (enc_valid)
  );

  assign pend_set = irq_src & ~prev_src;
  assign pend_clr = (reg_we && reg_addr == ADDR_PENDING) ? reg_wdata[NUM_SRC-1:0] : '0;
  assign take_req = (state == ST_IDLE) && gie && enc_valid;
  assign take_clr = take_req ? (NUM_SRC'(1) << enc_id) : '0;
  assign unused_wdata = ^reg_wdata;

`ifdef IRQ_CTRL_VECTORED_EN
  assign take_pc = VEC_BASE + (32'(enc_id) << 2);
`else
  assign take_pc = VEC_BASE;
`endif

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_ENABLE:  reg_rdata = 32'(enable);
      ADDR_PENDING: reg_rdata = 32'(pending);
      ADDR_EPC:     reg_rdata = epc;
      ADDR_STATUS:  begin
        reg_rdata[STATUS_GIE]  = gie;
        reg_rdata[STATUS_PGIE] = pgie;
      end
      default:      reg_rdata = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_src    <= '0;
      pending     <= '0;
      enable      <= '0;
      epc         <= '0;
      gie         <= 1'b0;
      pgie        <= 1'b0;
      irq_id      <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      irq_active  <= 1'b0;
    end else begin
      prev_src    <= irq_src;
      // A new edge wins over a software clear on the same cycle.
      pending     <= (pending & ~pend_clr & ~take_clr) | pend_set;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      if (reg_we && reg_addr == ADDR_ENABLE) enable <= reg_wdata[NUM_SRC-1:0];
      if (reg_we && reg_addr == ADDR_STATUS) gie <= reg_wdata[STATUS_GIE];

      // FSM updates to GIE come later so they override a software write.
      case (state)
        ST_IDLE: begin
          if (take_req) begin
            state       <= ST_TAKE;
            irq_id      <= enc_id;
            epc         <= pc_in;
            pgie        <= gie;
            gie         <= 1'b0;
            redirect    <= 1'b1;
            redirect_pc <= take_pc;
            irq_active  <= 1'b1;
          end
        end
        ST_TAKE: state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (mret) begin
            state       <= ST_RETURN;
            gie         <= pgie;
            redirect    <= 1'b1;
            redirect_pc <= epc;
            irq_active  <= 1'b0;
          end
        end
        ST_RETURN: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_irq_ctrl;

  localparam int          NUM_SRC  = 4;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic [31:0] pc_in;
  logic        mret;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_active;
  logic [1:0]  irq_id;

  int vectors = 0;
  int miscompares = 0;

  irq_ctrl #(.NUM_SRC(NUM_SRC), .VEC_BASE(VEC_BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_src     (irq_src),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .pc_in       (pc_in),
    .mret        (mret),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq_active  (irq_active),
    .irq_id      (irq_id)
  );

  always #5 clk = ~clk;

  // Behavioural model: handler bookkeeping as flags, not as a state encoding.
  logic [3:0]  m_prev, m_pend, m_en;
  logic [31:0] m_epc, m_rpc;
  logic        m_gie, m_pgie, m_redirect;
  logic        m_in_handler, m_just_taken, m_returning;
  logic [1:0]  m_id;

  function automatic int lowest_set(logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] vec_addr(int id);
`ifdef IRQ_CTRL_VECTORED_EN
    return VEC_BASE + 32'(4 * id);
`else
    return VEC_BASE + 32'(0 * id);
`endif
  endfunction

  function automatic logic [31:0] model_rdata(logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_en};
      2'd1:    return {28'd0, m_pend};
      2'd2:    return m_epc;
      default: return {30'd0, m_pgie, m_gie};
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] rise, clr, taken;
    logic       can_take, do_ret;
    int         id;
    if (reset) begin
      m_prev = 0; m_pend = 0; m_en = 0; m_epc = 0; m_gie = 0; m_pgie = 0;
      m_id = 0; m_redirect = 0; m_rpc = 0;
      m_in_handler = 0; m_just_taken = 0; m_returning = 0;
      return;
    end
    rise     = irq_src & ~m_prev;
    clr      = (reg_we && reg_addr == 2'd1) ? reg_wdata[3:0] : 4'd0;
    can_take = !m_in_handler && !m_returning && m_gie && ((m_pend & m_en) != 0);
    do_ret   = m_in_handler && !m_just_taken && mret;
    id       = lowest_set(m_pend & m_en);
    taken    = can_take ? 4'(1 << id) : 4'd0;
    m_pend   = (m_pend & ~clr & ~taken) | rise;
    if (reg_we && reg_addr == 2'd0) m_en = reg_wdata[3:0];
    m_redirect = can_take || do_ret;
    m_rpc      = 0;
    if (can_take) begin
      m_pgie = m_gie; m_gie = 0; m_epc = pc_in; m_id = 2'(id);
      m_rpc  = vec_addr(id);
    end else if (do_ret) begin
      m_gie = m_pgie;
      m_rpc = m_epc;
    end else if (reg_we && reg_addr == 2'd3) begin
      m_gie = reg_wdata[0];
    end
    m_returning  = do_ret;
    m_just_taken = can_take;
    m_in_handler = can_take || (m_in_handler && !do_ret);
    m_prev       = irq_src;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    reg_we = 1'b0;
    mret   = 1'b0;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (redirect !== 1'b0 || redirect_pc !== 32'd0 || irq_active !== 1'b0 || irq_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got redirect=%b pc=%h active=%b id=%0d, want 0/0/0/0",
               redirect, redirect_pc, irq_active, irq_id);
    end
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      vectors++;
      if (reg_rdata !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h want 0", a, reg_rdata);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_take_and_return();
    wr(2'd0, 32'h1);
    wr(2'd3, 32'h1);
    pc_in = 32'h40; irq_src = 4'b0001;
    tick();
    vectors++;
    if (redirect !== 1'b0) begin
      miscompares++; $display("FAIL take_early: got redirect=%b want 0", redirect);
    end
    tick();
    vectors++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100 || irq_active !== 1'b1 || irq_id !== 2'd0) begin
      miscompares++;
      $display("FAIL take_redirect: got %b/%h/%b/%0d want 1/00000100/1/0",
               redirect, redirect_pc, irq_active, irq_id);
    end
    reg_addr = 2'd2; #1;
    vectors++;
    if (reg_rdata !== 32'h40) begin
      miscompares++; $display("FAIL take_epc: got %h want 00000040", reg_rdata);
    end
    reg_addr = 2'd1; #1;
    vectors++;
    if (reg_rdata !== 32'h0) begin
      miscompares++; $display("FAIL take_pend_clr: got %h want 0", reg_rdata);
    end
    mret = 1'b1;
    tick();
    vectors++;
    if (redirect !== 1'b0 || irq_active !== 1'b1) begin
      miscompares++;
      $display("FAIL take_one_cycle: got redirect=%b active=%b want 0/1", redirect, irq_active);
    end
    wr(2'd2, 32'hDEAD_BEEF);
    reg_addr = 2'd2; #1;
    vectors++;
    if (reg_rdata !== 32'h40) begin
      miscompares++; $display("FAIL epc_readonly: got %h want 00000040", reg_rdata);
    end
    pc_in = 32'h999; mret = 1'b1;
    tick();
    reg_addr = 2'd3; #1;
    vectors++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h40 || irq_active !== 1'b0 || reg_rdata[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL return: got %b/%h/%b gie=%b want 1/00000040/0/1",
               redirect, redirect_pc, irq_active, reg_rdata[0]);
    end
    tick();
    vectors++;
    if (redirect !== 1'b0) begin
      miscompares++; $display("FAIL return_one_cycle: got %b want 0", redirect);
    end
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    wr(2'd0, 32'hF);
    irq_src = 4'b0110;
    tick();
    tick();
    vectors++;
    if (redirect !== 1'b1 || irq_id !== 2'd1 || redirect_pc !== vec_addr(1)) begin
      miscompares++;
      $display("FAIL prio_first: got %b id=%0d pc=%h want 1 id=1 pc=%h",
               redirect, irq_id, redirect_pc, vec_addr(1));
    end
    tick();
    mret = 1'b1;
    tick();
    tick();
    vectors++;
    if (redirect !== 1'b0) begin
      miscompares++; $display("FAIL prio_gap: got %b want 0", redirect);
    end
    tick();
    vectors++;
    if (redirect !== 1'b1 || irq_id !== 2'd2 || redirect_pc !== vec_addr(2)) begin
      miscompares++;
      $display("FAIL prio_second: got %b id=%0d pc=%h want 1 id=2 pc=%h",
               redirect, irq_id, redirect_pc, vec_addr(2));
    end
    tick();
    mret = 1'b1;
    tick();
    tick();
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_set_wins_and_gie_gate();
    wr(2'd3, 32'h0);
    irq_src = 4'b0001;
    reg_we = 1'b1; reg_addr = 2'd1; reg_wdata = 32'h1;
    tick();
    reg_addr = 2'd1; #1;
    vectors++;
    if (reg_rdata[0] !== 1'b1) begin
      miscompares++; $display("FAIL set_wins: got pending0=%b want 1", reg_rdata[0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (redirect !== 1'b0) begin
        miscompares++; $display("FAIL gie_gate cyc%0d: got redirect=%b want 0", i, redirect);
      end
    end
    wr(2'd3, 32'h1);
    vectors++;
    if (redirect !== 1'b0) begin
      miscompares++; $display("FAIL gie_early: got %b want 0", redirect);
    end
    tick();
    vectors++;
    if (redirect !== 1'b1 || redirect_pc !== vec_addr(0) || irq_id !== 2'd0) begin
      miscompares++;
      $display("FAIL gie_take: got %b pc=%h id=%0d want 1 pc=%h id=0",
               redirect, redirect_pc, irq_id, vec_addr(0));
    end
    tick();
    mret = 1'b1;
    tick();
    tick();
    irq_src = 4'b0000;
    tick();
  endtask

  task automatic test_reset_in_take();
    wr(2'd0, 32'h1);
    irq_src = 4'b0001;
    tick();
    tick();
    vectors++;
    if (redirect !== 1'b1) begin
      miscompares++; $display("FAIL rst_take_setup: got %b want 1", redirect);
    end
    reset = 1'b1; irq_src = 4'b0000;
    tick();
    vectors++;
    if (redirect !== 1'b0 || redirect_pc !== 32'd0 || irq_active !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_take: got %b/%h/%b want 0/0/0", redirect, redirect_pc, irq_active);
    end
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      vectors++;
      if (reg_rdata !== 32'd0) begin
        miscompares++; $display("FAIL rst_take_reg%0d: got %h want 0", a, reg_rdata);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom_range(0, 15));
      pc_in    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      reg_addr = 2'($urandom_range(0, 3));
      mret     = ($urandom_range(0, 5) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      reg_we   = ($urandom_range(0, 5) == 0);
      reg_wdata = $urandom;
      if (reg_addr == 2'd3) reg_wdata[0] = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if (redirect !== m_redirect || redirect_pc !== m_rpc || irq_active !== m_in_handler ||
          irq_id !== m_id || reg_rdata !== model_rdata(reg_addr)) begin
        miscompares++;
        $display("FAIL random cyc%0d (got/want): redirect %b/%b pc %h/%h active %b/%b id %0d/%0d rdata[%0d] %h/%h",
                 cyc, redirect, m_redirect, redirect_pc, m_rpc, irq_active, m_in_handler,
                 irq_id, m_id, reg_addr, reg_rdata, model_rdata(reg_addr));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; pc_in = '0; mret = 1'b0;
    test_reset();
    test_take_and_return();
    test_priority();
    test_set_wins_and_gie_gate();
    test_reset_in_take();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, the number of interrupt sources (2..8); bit 0 is the timer interrupt.
REQ-002 The block SHALL have parameter VEC_BASE, default 32'h0000_0100, the handler base address.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port irq_src, input, NUM_SRC bits: level interrupt requests, rising-edge sensitive.
REQ-007 The block SHALL have port reg_we, input, 1 bit: CPU register write strobe.
REQ-008 The block SHALL have port reg_addr, input, 2 bits: register select (0 ENABLE, 1 PENDING, 2 EPC, 3 STATUS).
REQ-009 The block SHALL have port reg_wdata, input, 32 bits: register write data.
REQ-010 The block SHALL have port reg_rdata, output, 32 bits: combinational read of the selected register, zero-extended.
REQ-011 The block SHALL have port pc_in, input, 32 bits: return PC supplied by fetch.
REQ-012 The block SHALL have port mret, input, 1 bit: single-cycle pulse marking return-from-interrupt.
REQ-013 The block SHALL have port redirect, output, 1 bit: single-cycle pulse; fetch loads redirect_pc.
REQ-014 The block SHALL have port redirect_pc, output, 32 bits: fetch target, valid only while redirect=1.
REQ-015 The block SHALL have port irq_active, output, 1 bit: high while a handler is running.
REQ-016 The block SHALL have port irq_id, output, $clog2(NUM_SRC) bits: index of the source being serviced.

Function
REQ-017 Pending bit i SHALL set on the edge where irq_src[i] is sampled 1 and was 0 on the previous edge.
REQ-018 A write to PENDING SHALL clear each bit written 1; a simultaneous set and clear SHALL resolve to set.
REQ-019 ENABLE SHALL be read/write over NUM_SRC bits; STATUS bit0 = GIE (read/write) and bit1 = PGIE (read-only); EPC SHALL be read-only, and writes to it SHALL be ignored.
REQ-020 The FSM SHALL implement IDLE, TAKE, ACTIVE and RETURN.
REQ-021 IDLE SHALL go to TAKE when GIE=1 and (PENDING & ENABLE)!=0.
REQ-022 On entry to TAKE, irq_id SHALL be set to the lowest set index, EPC to pc_in, and PGIE to GIE; GIE SHALL be cleared and that pending bit cleared.
REQ-023 TAKE SHALL assert redirect for exactly one cycle, then go to ACTIVE.
REQ-024 ACTIVE SHALL go to RETURN on mret=1; RETURN SHALL assert redirect with redirect_pc=EPC, restore GIE from PGIE, then go to IDLE.
REQ-025 Latency SHALL be fixed: with an enabled source and GIE=1, a rising edge sampled at edge k SHALL produce redirect high in the cycle after edge k+1.
REQ-026 irq_active SHALL be 1 in TAKE and ACTIVE and 0 otherwise; nesting SHALL NOT occur.
REQ-027 mret outside ACTIVE SHALL be ignored, and new edges during ACTIVE SHALL only set pending.

Reset
REQ-028 Reset SHALL force IDLE and clear PENDING, ENABLE, EPC, GIE, PGIE, irq_id and the edge history; outputs SHALL be redirect=0, redirect_pc=0 and irq_active=0.
REQ-029 Reset in any state, including mid-TAKE or RETURN, SHALL produce no redirect in the following cycle.

Configuration
REQ-030 With IRQ_CTRL_VECTORED_EN defined, TAKE redirect_pc SHALL be VEC_BASE + 4*irq_id.
REQ-031 Without IRQ_CTRL_VECTORED_EN, TAKE redirect_pc SHALL be VEC_BASE for all sources, and irq_id SHALL be unchanged.

Structure
REQ-032 Package irq_pkg SHALL hold the FSM state enum, the register address constants and the STATUS bit positions.
REQ-033 Sub-module irq_prio_enc SHALL provide the lowest-index priority encoder, with a NUM_SRC-bit input, an id output and a valid output.

Verification
REQ-034 Test: ENABLE=1, GIE=1, irq_src[0] rises at edge k -> redirect with redirect_pc=0x100 in the cycle after k+1, and EPC=pc_in.
REQ-035 Test: sources 2 and 1 rise together, vectored build -> service id 1 at 0x104; after mret, id 2 is taken at 0x108.
REQ-036 Test: ACTIVE with pc_in captured as 0x40, pulse mret -> redirect_pc=0x40 one cycle later, and GIE=1.
REQ-037 Test: write PENDING=0x1 on the same edge as a source-0 rising edge -> PENDING[0] remains 1.
REQ-038 Test: GIE=0 with a pending source -> no redirect; set GIE=1 -> redirect two cycles later.
REQ-039 Test: reset asserted during TAKE -> redirect=0 next cycle, and all registers read 0.
